dual_port_scratchpad: RTL

DUAL_PORT_SCRATCHPAD -- requirements
Module: dual_port_scratchpad

---
 rtl/dual_port_scratchpad_pkg.sv | 32 +++
 rtl/dual_port_scratchpad_if.sv | 37 +++
 rtl/dual_port_scratchpad_lane_align.sv | 54 +++++
 rtl/dual_port_scratchpad.sv | 106 ++++++++++
 4 files changed

// File: rtl/dual_port_scratchpad_pkg.sv
// Shared memory-interface definitions: command/type encodings, the response
// pipeline record and the load/store type legality check.
package dual_port_scratchpad_pkg;

    // Memory command encodings
    localparam logic M_XRD = 1'b0;
    localparam logic M_XWR = 1'b1;

    // Memory access type encodings
    localparam logic [2:0] MT_X  = 3'd0;
    localparam logic [2:0] MT_B  = 3'd1;
    localparam logic [2:0] MT_H  = 3'd2;
    localparam logic [2:0] MT_W  = 3'd3;
    localparam logic [2:0] MT_BU = 3'd5;
    localparam logic [2:0] MT_HU = 3'd6;

    // One response pipeline stage; data and err are kept at 0 when vld is 0
    typedef struct packed {
        logic        vld;
        logic        err;
        logic [31:0] data;
    } resp_stage_t;

    // True for the five access types the scratchpad understands
    function automatic logic typ_legal(input logic [2:0] typ);
        case (typ)
            MT_B, MT_H, MT_W, MT_BU, MT_HU: typ_legal = 1'b1;
            default:                        typ_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dual_port_scratchpad_if.sv
// Instruction-fetch and data request/response bundle of the scratchpad.
interface dual_port_scratchpad_if;

    logic        io_imem_req_valid;
    logic [31:0] io_imem_req_bits_addr;
    logic        io_imem_resp_valid;
    logic [31:0] io_imem_resp_bits_data;
    logic        io_imem_err;

    logic        io_dmem_req_valid;
    logic [31:0] io_dmem_req_bits_addr;
    logic [31:0] io_dmem_req_bits_data;
    logic        io_dmem_req_bits_fcn;
    logic [2:0]  io_dmem_req_bits_typ;
    logic        io_dmem_resp_valid;
    logic [31:0] io_dmem_resp_bits_data;
    logic        io_dmem_err;

    // Core side: issues requests, consumes responses
    modport master (
        output io_imem_req_valid, io_imem_req_bits_addr,
        input  io_imem_resp_valid, io_imem_resp_bits_data, io_imem_err,
        output io_dmem_req_valid, io_dmem_req_bits_addr, io_dmem_req_bits_data,
        output io_dmem_req_bits_fcn, io_dmem_req_bits_typ,
        input  io_dmem_resp_valid, io_dmem_resp_bits_data, io_dmem_err
    );

    // Scratchpad side: accepts requests, produces responses
    modport slave (
        input  io_imem_req_valid, io_imem_req_bits_addr,
        output io_imem_resp_valid, io_imem_resp_bits_data, io_imem_err,
        input  io_dmem_req_valid, io_dmem_req_bits_addr, io_dmem_req_bits_data,
        input  io_dmem_req_bits_fcn, io_dmem_req_bits_typ,
        output io_dmem_resp_valid, io_dmem_resp_bits_data, io_dmem_err
    );

endinterface

// File: rtl/dual_port_scratchpad_lane_align.sv
// Byte-lane logic for the data port: byte enables, store-data replication,
// load lane extraction with sign/zero extension, and alignment checking.
module sp_lane_align
    import dual_port_scratchpad_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  typ,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic [3:0]  be,
    output logic [31:0] st_word,
    output logic [31:0] ld_data,
    output logic        misaligned
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Decode access type into lane enables, replicated store word and load result
    always_comb begin
        be         = 4'b0000;
        st_word    = 32'h0;
        ld_data    = 32'h0;
        misaligned = 1'b0;
        ld_half    = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
        case (addr_lo)
            2'd0:    ld_byte = ld_word[7:0];
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        case (typ)
            MT_B, MT_BU: begin
                be      = 4'b0001 << addr_lo;
                st_word = {4{st_data[7:0]}};
                ld_data = (typ == MT_B) ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
            end
            MT_H, MT_HU: begin
                misaligned = addr_lo[0];
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                st_word    = {2{st_data[15:0]}};
                ld_data    = (typ == MT_H) ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
            end
            MT_W: begin
                misaligned = (addr_lo != 2'd0);
                be         = 4'b1111;
                st_word    = st_data;
                ld_data    = ld_word;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dual_port_scratchpad.sv
// Dual-port word scratchpad: a read/write data port and a read-only fetch
// port onto one byte-lane RAM. Memory is read in the accept cycle and the
// formatted result is then delayed so every response lands LATENCY cycles
// after its request. LATENCY must lie in 1..4.
module dual_port_scratchpad
    import dual_port_scratchpad_pkg::*;
#(
    parameter int          DEPTH_WORDS = 16384,
    parameter int          LATENCY     = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                   clock,
    input  logic                   reset,
    dual_port_scratchpad_if.slave  bus
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [3:0][7:0] mem_q [DEPTH_WORDS];

    // Fetch port address decode
    logic [31:0] i_off, i_idx, i_word;
    logic        i_err;
    resp_stage_t i_stage;

    assign i_off  = bus.io_imem_req_bits_addr - BASE_ADDR;
    assign i_idx  = i_off >> 2;
    assign i_err  = (i_idx >= 32'(DEPTH_WORDS)) || (bus.io_imem_req_bits_addr[1:0] != 2'b00);
    assign i_word = mem_q[i_idx[AW-1:0]];

    assign i_stage.vld  = bus.io_imem_req_valid;
    assign i_stage.err  = bus.io_imem_req_valid & i_err;
    assign i_stage.data = (bus.io_imem_req_valid && !i_err) ? i_word : 32'h0;

    // Data port address decode and lane handling
    logic [31:0] d_off, d_idx, d_word, d_st_word, d_ld_data;
    logic [3:0]  d_be;
    logic        d_misaligned, d_err, d_is_wr, d_we;
    resp_stage_t d_stage;

    assign d_off   = bus.io_dmem_req_bits_addr - BASE_ADDR;
    assign d_idx   = d_off >> 2;
    assign d_word  = mem_q[d_idx[AW-1:0]];
    assign d_is_wr = (bus.io_dmem_req_bits_fcn == M_XWR);

    sp_lane_align u_lane (
        .addr_lo    (bus.io_dmem_req_bits_addr[1:0]),
        .typ        (bus.io_dmem_req_bits_typ),
        .st_data    (bus.io_dmem_req_bits_data),
        .ld_word    (d_word),
        .be         (d_be),
        .st_word    (d_st_word),
        .ld_data    (d_ld_data),
        .misaligned (d_misaligned)
    );

    assign d_err = !typ_legal(bus.io_dmem_req_bits_typ) || d_misaligned
                   || (d_idx >= 32'(DEPTH_WORDS));
    // Requests seen while reset is held are ignored, so the write is gated too
    assign d_we  = reset && bus.io_dmem_req_valid && d_is_wr && !d_err;

    assign d_stage.vld  = bus.io_dmem_req_valid;
    assign d_stage.err  = bus.io_dmem_req_valid & d_err;
    assign d_stage.data = (bus.io_dmem_req_valid && !d_err && !d_is_wr) ? d_ld_data : 32'h0;

    // Byte-lane write from the data port; old contents are seen by a same-cycle fetch
    always_ff @(posedge clock) begin
        if (d_we) begin
            if (d_be[0]) mem_q[d_idx[AW-1:0]][0] <= d_st_word[7:0];
            if (d_be[1]) mem_q[d_idx[AW-1:0]][1] <= d_st_word[15:8];
            if (d_be[2]) mem_q[d_idx[AW-1:0]][2] <= d_st_word[23:16];
            if (d_be[3]) mem_q[d_idx[AW-1:0]][3] <= d_st_word[31:24];
        end
    end

    // Response delay lines; entry 0 is the newest, entry LATENCY-1 drives the outputs
    resp_stage_t [LATENCY-1:0] i_pipe_q, i_pipe_d;
    resp_stage_t [LATENCY-1:0] d_pipe_q, d_pipe_d;

    if (LATENCY > 1) begin : g_shift
        assign i_pipe_d = {i_pipe_q[LATENCY-2:0], i_stage};
        assign d_pipe_d = {d_pipe_q[LATENCY-2:0], d_stage};
    end else begin : g_single
        assign i_pipe_d = i_stage;
        assign d_pipe_d = d_stage;
    end

    // Advance both pipelines; reset drops everything in flight immediately
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            i_pipe_q <= '0;
            d_pipe_q <= '0;
        end else begin
            i_pipe_q <= i_pipe_d;
            d_pipe_q <= d_pipe_d;
        end
    end

    assign bus.io_imem_resp_valid     = i_pipe_q[LATENCY-1].vld;
    assign bus.io_imem_resp_bits_data = i_pipe_q[LATENCY-1].data;
    assign bus.io_imem_err            = i_pipe_q[LATENCY-1].err;
    assign bus.io_dmem_resp_valid     = d_pipe_q[LATENCY-1].vld;
    assign bus.io_dmem_resp_bits_data = d_pipe_q[LATENCY-1].data;
    assign bus.io_dmem_err            = d_pipe_q[LATENCY-1].err;

endmodule
